// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM command path: command-word field positions,
// ramp FSM states and the default duty magnitude width.
package pwm_pkg;

  localparam int MAG_W_DEF = 11;
  localparam int DUTY_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    DWELL = 2'd2
  } state_e;

  // Word layout is {hb, dir, duty[mag_w-1:0]}
  function automatic int hb_bit(input int mag_w);
    return mag_w + 1;
  endfunction

  function automatic int dir_bit(input int mag_w);
    return mag_w;
  endfunction

  function automatic int duty_msb(input int mag_w);
    return mag_w - 1;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Free-running prescaler: o_tick is high for one clk cycle every TICK_DIV cycles.
module pwm_tick_gen #(
  parameter int TICK_DIV = 5000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..TICK_DIV-1 and wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/pwm_cmd_ramp.sv
// Slew-limited PWM command stage with zero-duty dwell before reversal and a
// per-command heartbeat. Optional deadband: define PWM_CMD_RAMP_DEADBAND_EN.
module pwm_cmd_ramp
  import pwm_pkg::*;
#(
  parameter int MAG_W       = MAG_W_DEF,
  parameter int TICK_DIV    = 5000,
  parameter int STEP        = 8,
  parameter int DWELL_TICKS = 4,
  parameter int DEADBAND    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [MAG_W:0]   cmd_speed,
  output logic [MAG_W+1:0] pwm_word,
  output logic             at_target,
  output logic             busy
);

  localparam int XW       = MAG_W + 1;
  localparam int HB_BIT   = hb_bit(MAG_W);
  localparam int DIR_BIT  = dir_bit(MAG_W);
  localparam int DUTY_MSB = duty_msb(MAG_W);
  localparam logic [XW-1:0] MAX_MAG = {1'b0, {MAG_W{1'b1}}};
  localparam logic [XW-1:0] STEP_W  = XW'(STEP);
  localparam logic [XW-1:0] DB_W    = XW'(DEADBAND);
  localparam int DW_CW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [DW_CW-1:0] DW_LAST = DW_CW'(DWELL_TICKS - 1);
`ifdef PWM_CMD_RAMP_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  state_e             r_state, w_state_nxt;
  logic [MAG_W-1:0]   r_duty, w_duty_nxt, r_tmag, w_tmag_nxt;
  logic               r_dir, w_dir_nxt, r_tdir, w_tdir_nxt, r_hb, w_hb_nxt;
  logic [DW_CW-1:0]   r_dwell, w_dwell_nxt;
  logic               r_cmd_ready, r_at_target, r_busy;
  logic               w_tick, w_accept, w_new_dir, w_differs;
  logic [XW-1:0]      w_abs, w_sat, w_duty_ext, w_tmag_ext, w_up, w_dn, w_toward;
  logic [MAG_W-1:0]   w_new_mag;

  pwm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  // The most-negative speed has no positive twin, so it saturates to full scale
  assign w_abs     = cmd_speed[MAG_W] ? (~cmd_speed + XW'(1)) : cmd_speed;
  assign w_sat     = (w_abs > MAX_MAG) ? MAX_MAG : w_abs;
  assign w_new_mag = (DB_EN && (w_sat < DB_W)) ? '0 : w_sat[MAG_W-1:0];
  assign w_new_dir = cmd_speed[MAG_W];
  assign w_accept  = cmd_valid && r_cmd_ready && enable;
  assign w_differs = (w_new_mag != r_duty) || ((w_new_mag != '0) && (w_new_dir != r_dir));

  assign w_duty_ext = {1'b0, r_duty};
  assign w_tmag_ext = {1'b0, r_tmag};
  assign w_up       = w_duty_ext + STEP_W;
  assign w_dn       = (w_duty_ext > STEP_W) ? (w_duty_ext - STEP_W) : '0;
  assign w_toward   = (w_duty_ext < w_tmag_ext) ? ((w_up > w_tmag_ext) ? w_tmag_ext : w_up)
                                                : ((w_dn < w_tmag_ext) ? w_tmag_ext : w_dn);

  // Next-state, target latch and ramp arithmetic
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir;
    w_tmag_nxt  = r_tmag;
    w_tdir_nxt  = r_tdir;
    w_hb_nxt    = r_hb;
    w_dwell_nxt = r_dwell;
    if (!enable) begin
      w_duty_nxt  = '0;
      w_tmag_nxt  = '0;
      w_state_nxt = IDLE;
      w_dwell_nxt = '0;
    end else begin
      if (w_accept) begin
        w_tmag_nxt = w_new_mag;
        w_tdir_nxt = w_new_dir;
        w_hb_nxt   = ~r_hb;
      end else begin
        w_hb_nxt   = r_hb;
      end
      case (r_state)
        IDLE: begin
          if (w_accept && w_differs) begin
            if ((r_duty == '0) && (w_new_mag != '0) && (w_new_dir != r_dir)) begin
              w_state_nxt = DWELL;
              w_dwell_nxt = '0;
            end else begin
              w_state_nxt = RAMP;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        RAMP: begin
          if (w_tick) begin
            if ((r_tmag == '0) || (r_dir == r_tdir)) begin
              w_duty_nxt = w_toward[MAG_W-1:0];
              // A fresh command on the arrival tick keeps ramping toward it
              if ((w_toward == w_tmag_ext) && !w_accept) begin
                w_state_nxt = IDLE;
              end else begin
                w_state_nxt = RAMP;
              end
            end else begin
              w_duty_nxt = w_dn[MAG_W-1:0];
              if (w_dn == '0) begin
                w_state_nxt = DWELL;
                w_dwell_nxt = '0;
              end else begin
                w_state_nxt = RAMP;
              end
            end
          end else begin
            w_state_nxt = RAMP;
          end
        end
        DWELL: begin
          w_duty_nxt = '0;
          if (w_tick) begin
            if (r_dwell == DW_LAST) begin
              w_dwell_nxt = '0;
              if (r_tmag == '0) begin
                w_state_nxt = IDLE;
              end else begin
                w_dir_nxt   = r_tdir;
                w_state_nxt = RAMP;
              end
            end else begin
              w_dwell_nxt = r_dwell + DW_CW'(1);
            end
          end else begin
            w_dwell_nxt = r_dwell;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_duty      <= '0;
      r_dir       <= 1'b0;
      r_tmag      <= '0;
      r_tdir      <= 1'b0;
      r_hb        <= 1'b0;
      r_dwell     <= '0;
      r_cmd_ready <= 1'b0;
      r_at_target <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_duty      <= w_duty_nxt;
      r_dir       <= w_dir_nxt;
      r_tmag      <= w_tmag_nxt;
      r_tdir      <= w_tdir_nxt;
      r_hb        <= w_hb_nxt;
      r_dwell     <= w_dwell_nxt;
      r_cmd_ready <= enable && (w_state_nxt != DWELL);
      r_at_target <= (w_state_nxt == IDLE) && (w_duty_nxt == w_tmag_nxt) &&
                     ((w_duty_nxt == '0) || (w_dir_nxt == w_tdir_nxt));
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  // Pack the command word from its registered fields
  always_comb begin
    pwm_word                    = '0;
    pwm_word[HB_BIT]            = r_hb;
    pwm_word[DIR_BIT]           = r_dir;
    pwm_word[DUTY_MSB:DUTY_LSB] = r_duty;
  end

  assign cmd_ready = r_cmd_ready;
  assign at_target = r_at_target;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pwm_cmd_ramp.sv
// Directed bench for pwm_cmd_ramp with a fast tick (TICK_DIV=4, STEP=8).
module tb_pwm_cmd_ramp;

  localparam int MAG_W = 11;
  localparam int STEP  = 8;

  logic             clk = 1'b0;
  logic             rst_n, enable, cmd_valid, cmd_ready, at_target, busy;
  logic [MAG_W:0]   cmd_speed;
  logic [MAG_W+1:0] pwm_word;

  int n_checks = 0;
  int n_fails  = 0;
  int n_changes = 0;
  int viol_step = 0;
  int viol_dir  = 0;
  bit mon_en = 1'b0;
  logic [MAG_W-1:0] prev_duty = '0;
  logic             prev_dir  = 1'b0;
  int base;
  int n;

  always #5 clk = ~clk;

  pwm_cmd_ramp #(
    .MAG_W(MAG_W), .TICK_DIV(4), .STEP(STEP), .DWELL_TICKS(4), .DEADBAND(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_speed (cmd_speed),
    .pwm_word  (pwm_word),
    .at_target (at_target),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and track ramp behaviour there
  task automatic step();
    int d;
    @(negedge clk);
    d = int'(pwm_word[MAG_W-1:0]) - int'(prev_duty);
    if (mon_en) begin
      if (d != 0) n_changes++;
      if (d > STEP || d < -STEP) viol_step++;
      if (pwm_word[MAG_W] != prev_dir && (pwm_word[MAG_W-1:0] != 0 || prev_duty != 0)) viol_dir++;
    end
    prev_duty = pwm_word[MAG_W-1:0];
    prev_dir  = pwm_word[MAG_W];
  endtask

  task automatic send_cmd(input int spd);
    int k = 0;
    while (!cmd_ready && k < 50) begin step(); k++; end
    check_eq("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_speed = 12'(spd);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_at_target(input int budget, input string tag);
    int k = 0;
    while (!at_target && k < budget) begin step(); k++; end
    check_eq(tag, at_target, 1);
  endtask

  task automatic wait_duty(input int value, input int budget, input string tag);
    int k = 0;
    while (int'(pwm_word[MAG_W-1:0]) != value && k < budget) begin step(); k++; end
    check_eq(tag, pwm_word[MAG_W-1:0], value);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_speed = '0;
    step(); step();
    check_eq("rst_word", pwm_word, 0);
    check_eq("rst_ready", cmd_ready, 0);
    check_eq("rst_at_target", at_target, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    check_eq("ready_first_cycle", cmd_ready, 0);
    step();
    check_eq("ready_second_cycle", cmd_ready, 1);
    mon_en = 1'b1;

    // +1000 from rest
    base = n_changes;
    send_cmd(1000);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_hb", pwm_word[12], 1);
    wait_at_target(600, "t1_at_target");
    check_eq("t1_word", pwm_word, {1'b1, 1'b0, 11'd1000});
    check_eq("t1_steps", n_changes - base, 125);

    // Reverse to -500 through a zero-duty dwell
    base = n_changes;
    send_cmd(-500);
    wait_duty(0, 700, "t2_down");
    check_eq("t2_down_steps", n_changes - base, 125);
    check_eq("t2_dwell_ready", cmd_ready, 0);
    check_eq("t2_dwell_busy", busy, 1);
    check_eq("t2_dwell_at_target", at_target, 0);
    check_eq("t2_dwell_dir", pwm_word[11], 0);
    n = 0;
    while (pwm_word[11] == 1'b0 && n < 40) begin step(); n++; end
    check_eq("t2_dwell_len", n, 16);
    check_eq("t2_flip_duty", pwm_word[10:0], 0);
    wait_at_target(400, "t2_at_target");
    check_eq("t2_word", pwm_word, {1'b0, 1'b1, 11'd500});
    check_eq("t2_steps", n_changes - base, 188);

    // Most-negative command saturates; last step is partial
    base = n_changes;
    send_cmd(-2048);
    check_eq("t3_hb", pwm_word[12], 1);
    wait_at_target(900, "t3_at_target");
    check_eq("t3_word", pwm_word, {1'b1, 1'b1, 11'd2047});
    check_eq("t3_steps", n_changes - base, 194);
    check_eq("t3_ready", cmd_ready, 1);

    // Zero target ramps down without touching dir
    base = n_changes;
    send_cmd(0);
    wait_at_target(1200, "t4_zero_at_target");
    check_eq("t4_zero_word", pwm_word, {1'b0, 1'b1, 11'd0});
    check_eq("t4_zero_steps", n_changes - base, 256);

    // Reversal from zero duty dwells first, then disable mid-ramp
    send_cmd(600);
    check_eq("t4_dwell_busy", busy, 1);
    check_eq("t4_dwell_ready", cmd_ready, 0);
    wait_duty(304, 400, "t4_reach_304");
    check_eq("t4_dir", pwm_word[11], 0);
    mon_en = 1'b0;
    enable = 1'b0; cmd_valid = 1'b1; cmd_speed = 12'd100;
    step();
    check_eq("t4_off_duty", pwm_word[10:0], 0);
    check_eq("t4_off_ready", cmd_ready, 0);
    check_eq("t4_off_busy", busy, 0);
    check_eq("t4_off_hb", pwm_word[12], 1);
    repeat (4) step();
    check_eq("t4_off_word", pwm_word, {1'b1, 1'b0, 11'd0});
    check_eq("t4_off_ready_held", cmd_ready, 0);
    cmd_valid = 1'b0; enable = 1'b1;
    check_eq("t4_reen_ready0", cmd_ready, 0);
    step();
    check_eq("t4_reen_ready1", cmd_ready, 1);
    check_eq("t4_reen_at_target", at_target, 1);

    // Asynchronous reset in the middle of a dwell
    send_cmd(-200);
    check_eq("t5_busy", busy, 1);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_word", pwm_word, 0);
    check_eq("t5_rst_ready", cmd_ready, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_at_target", at_target, 0);
    step(); step();
    rst_n = 1'b1; cmd_valid = 1'b1; cmd_speed = 12'd10;
    check_eq("t5_rel_ready", cmd_ready, 0);
    step();
    check_eq("t5_no_early_accept", pwm_word[12], 0);
    step();
    check_eq("t5_accept", pwm_word[12], 1);
    cmd_valid = 1'b0;

    // Small command: deadband zeroes it, otherwise two ticks to reach 10
    mon_en = 1'b1;
    base = n_changes;
    wait_at_target(40, "t6_at_target");
`ifdef PWM_CMD_RAMP_DEADBAND_EN
    check_eq("t6_word", pwm_word, {1'b1, 1'b0, 11'd0});
    check_eq("t6_steps", n_changes - base, 0);
`else
    check_eq("t6_word", pwm_word, {1'b1, 1'b0, 11'd10});
    check_eq("t6_steps", n_changes - base, 2);
`endif

    // Identical command still produces a heartbeat
    send_cmd(10);
    check_eq("t7_hb", pwm_word[12], 0);
    check_eq("t7_busy", busy, 0);
    check_eq("t7_at_target", at_target, 1);
`ifdef PWM_CMD_RAMP_DEADBAND_EN
    check_eq("t7_duty", pwm_word[10:0], 0);
`else
    check_eq("t7_duty", pwm_word[10:0], 10);
`endif

    check_eq("mon_step_size", viol_step, 0);
    check_eq("mon_dir_at_nonzero_duty", viol_dir, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
